// File: rtl/streaming_clause_evaluator.sv
// Streams a clause as fixed-width literal chunks and emits one SAT/UNIT/CONFLICT/UNRESOLVED verdict per clause.
// Optional build macro SCE_EARLY_SAT_EN: issue SAT as soon as it is known, then drain the rest of the clause.
module streaming_clause_evaluator #(
    parameter int LITS_PER_CHUNK = 5,
    parameter int VAR_IDX_W      = 9,
    parameter int MAX_CHUNKS     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    input  logic [LITS_PER_CHUNK-1:0]           in_mask,
    input  logic [LITS_PER_CHUNK-1:0]           in_unassign,
    input  logic [LITS_PER_CHUNK-1:0]           in_assignment,
    input  logic [LITS_PER_CHUNK-1:0]           in_pole,
    input  logic [LITS_PER_CHUNK*VAR_IDX_W-1:0] in_vars,
    input  logic                                abort,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [1:0]                          out_status,
    output logic [VAR_IDX_W-1:0]                out_implied_var,
    output logic                                out_new_assignment,
    output logic                                out_overflow
);

    // state  | meaning
    // ACCUM  | accepting beats and accumulating clause state
    // RESULT | verdict presented, held until out_ready
    // DRAIN  | early SAT presented, discarding beats until in_last

    localparam int         BCNT_W  = $clog2(MAX_CHUNKS + 1);
    localparam logic [1:0] ST_UNRES = 2'b00;
    localparam logic [1:0] ST_SAT   = 2'b01;
    localparam logic [1:0] ST_UNIT  = 2'b10;
    localparam logic [1:0] ST_CONF  = 2'b11;

`ifdef SCE_EARLY_SAT_EN
    typedef enum logic [1:0] {ACCUM, RESULT, DRAIN} state_t;
`else
    typedef enum logic [0:0] {ACCUM, RESULT} state_t;
`endif

    state_t                state_q, state_d;
    logic                  sat_q, sat_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [VAR_IDX_W-1:0]  cap_var_q, cap_var_d;
    logic                  cap_pole_q, cap_pole_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            status_q, status_d;
    logic [VAR_IDX_W-1:0]  ivar_q, ivar_d;
    logic                  nasg_q, nasg_d;
    logic                  oovf_q, oovf_d;
`ifdef SCE_EARLY_SAT_EN
    logic                  last_seen_q, last_seen_d;
    logic                  consumed_q, consumed_d;
`endif

    logic                  beat_sat;
    logic [1:0]            beat_pc;
    logic [VAR_IDX_W-1:0]  beat_var;
    logic                  beat_pole;

    // Descending scan so the lowest unassigned slot is the one left captured.
    always_comb begin
        beat_sat  = 1'b0;
        beat_pc   = 2'd0;
        beat_var  = '0;
        beat_pole = 1'b0;
        for (int i = LITS_PER_CHUNK - 1; i >= 0; i--) begin
            if (in_mask[i] && in_unassign[i]) begin
                beat_var  = in_vars[i*VAR_IDX_W +: VAR_IDX_W];
                beat_pole = in_pole[i];
                if (beat_pc != 2'd2) beat_pc = beat_pc + 2'd1;
            end else if (in_mask[i] && (in_assignment[i] == in_pole[i])) begin
                beat_sat = 1'b1;
            end
        end
    end

    logic                  sat_new;
    logic [2:0]            cnt_sum;
    logic [1:0]            cnt_new;
    logic [VAR_IDX_W-1:0]  cap_var_new;
    logic                  cap_pole_new;
    logic                  bcnt_full;
    logic [BCNT_W-1:0]     bcnt_new;
    logic                  ovf_new;
    logic [1:0]            v_status;

    always_comb begin
        sat_new      = sat_q | beat_sat;
        cnt_sum      = {1'b0, cnt_q} + {1'b0, beat_pc};
        cnt_new      = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
        cap_var_new  = cap_var_q;
        cap_pole_new = cap_pole_q;
        if (cnt_q == 2'd0 && beat_pc != 2'd0) begin
            cap_var_new  = beat_var;
            cap_pole_new = beat_pole;
        end
        bcnt_full = (bcnt_q == BCNT_W'(MAX_CHUNKS));
        bcnt_new  = bcnt_full ? bcnt_q : bcnt_q + 1'b1;
        ovf_new   = ovf_q | bcnt_full;
        if (sat_new)             v_status = ST_SAT;
        else if (cnt_new == 2'd1) v_status = ST_UNIT;
        else if (cnt_new == 2'd0) v_status = ST_CONF;
        else                     v_status = ST_UNRES;
    end

    logic clr;

    always_comb begin
        state_d    = state_q;
        sat_d      = sat_q;
        cnt_d      = cnt_q;
        cap_var_d  = cap_var_q;
        cap_pole_d = cap_pole_q;
        bcnt_d     = bcnt_q;
        ovf_d      = ovf_q;
        status_d   = status_q;
        ivar_d     = ivar_q;
        nasg_d     = nasg_q;
        oovf_d     = oovf_q;
`ifdef SCE_EARLY_SAT_EN
        last_seen_d = last_seen_q;
        consumed_d  = consumed_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        clr       = 1'b0;

        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (abort) begin
                    clr = 1'b1;
                end else if (in_valid) begin
                    sat_d      = sat_new;
                    cnt_d      = cnt_new;
                    cap_var_d  = cap_var_new;
                    cap_pole_d = cap_pole_new;
                    bcnt_d     = bcnt_new;
                    ovf_d      = ovf_new;
                    if (in_last
`ifdef SCE_EARLY_SAT_EN
                        || sat_new
`endif
                    ) begin
                        status_d = v_status;
                        ivar_d   = (v_status == ST_UNIT) ? cap_var_new : '0;
                        nasg_d   = (v_status == ST_UNIT) ? cap_pole_new : 1'b0;
                        oovf_d   = ovf_new;
                        state_d  = RESULT;
`ifdef SCE_EARLY_SAT_EN
                        if (!in_last) begin
                            state_d     = DRAIN;
                            last_seen_d = 1'b0;
                            consumed_d  = 1'b0;
                        end
`endif
                    end
                end
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clr     = 1'b1;
                    state_d = ACCUM;
                end
            end
`ifdef SCE_EARLY_SAT_EN
            DRAIN: begin
                in_ready    = 1'b1;
                out_valid   = ~consumed_q;
                last_seen_d = last_seen_q | (in_valid & in_last);
                consumed_d  = consumed_q | out_ready;
                if (last_seen_d && consumed_d) begin
                    clr     = 1'b1;
                    state_d = ACCUM;
                end
            end
`endif
            default: state_d = ACCUM;
        endcase

        if (clr) begin
            sat_d      = 1'b0;
            cnt_d      = 2'd0;
            cap_var_d  = '0;
            cap_pole_d = 1'b0;
            bcnt_d     = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            sat_q      <= 1'b0;
            cnt_q      <= 2'd0;
            cap_var_q  <= '0;
            cap_pole_q <= 1'b0;
            bcnt_q     <= '0;
            ovf_q      <= 1'b0;
            status_q   <= ST_UNRES;
            ivar_q     <= '0;
            nasg_q     <= 1'b0;
            oovf_q     <= 1'b0;
`ifdef SCE_EARLY_SAT_EN
            last_seen_q <= 1'b0;
            consumed_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sat_q      <= sat_d;
            cnt_q      <= cnt_d;
            cap_var_q  <= cap_var_d;
            cap_pole_q <= cap_pole_d;
            bcnt_q     <= bcnt_d;
            ovf_q      <= ovf_d;
            status_q   <= status_d;
            ivar_q     <= ivar_d;
            nasg_q     <= nasg_d;
            oovf_q     <= oovf_d;
`ifdef SCE_EARLY_SAT_EN
            last_seen_q <= last_seen_d;
            consumed_q  <= consumed_d;
`endif
        end
    end

    assign out_status         = status_q;
    assign out_implied_var    = ivar_q;
    assign out_new_assignment = nasg_q;
    assign out_overflow       = oovf_q;

endmodule

// File: tb/tb_streaming_clause_evaluator.sv
// Self-checking bench for streaming_clause_evaluator (default build): directed clauses plus random clauses
// checked against a literal-by-literal reference model of the clause verdict.
module tb_streaming_clause_evaluator;

    localparam int L = 5;
    localparam int W = 9;
    localparam int M = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_last = 1'b0;
    logic [L-1:0]     in_mask = '0;
    logic [L-1:0]     in_unassign = '0;
    logic [L-1:0]     in_assignment = '0;
    logic [L-1:0]     in_pole = '0;
    logic [L*W-1:0]   in_vars = '0;
    logic             abort = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out_status;
    logic [W-1:0]     out_implied_var;
    logic             out_new_assignment;
    logic             out_overflow;

    always #5 clk = ~clk;

    streaming_clause_evaluator #(.LITS_PER_CHUNK(L), .VAR_IDX_W(W), .MAX_CHUNKS(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_mask(in_mask), .in_unassign(in_unassign), .in_assignment(in_assignment),
        .in_pole(in_pole), .in_vars(in_vars), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_status(out_status),
        .out_implied_var(out_implied_var), .out_new_assignment(out_new_assignment),
        .out_overflow(out_overflow)
    );

    int checks = 0;
    int errors = 0;

    logic [L-1:0]   bm [16];
    logic [L-1:0]   bu [16];
    logic [L-1:0]   ba [16];
    logic [L-1:0]   bp [16];
    logic [L*W-1:0] bv [16];
    int             nb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int b, input logic [L-1:0] m, input logic [L-1:0] u,
                            input logic [L-1:0] a, input logic [L-1:0] p);
        bm[b] = m; bu[b] = u; ba[b] = a; bp[b] = p;
        bv[b] = 45'({$urandom, $urandom});
    endtask

    // Reference: walk every live literal in stream order; overflow is simply "more beats than allowed".
    task automatic model(output logic [1:0] st, output logic [W-1:0] v, output logic a, output logic ovf);
        bit       sat;
        int       un;
        logic [W-1:0] fv;
        logic     fp;
        sat = 0; un = 0; fv = '0; fp = 1'b0;
        for (int b = 0; b < nb; b++)
            for (int s = 0; s < L; s++)
                if (bm[b][s]) begin
                    if (bu[b][s]) begin
                        if (un == 0) begin fv = bv[b][s*W +: W]; fp = bp[b][s]; end
                        un++;
                    end else if (ba[b][s] == bp[b][s]) sat = 1;
                end
        if (sat)          st = 2'b01;
        else if (un == 1) st = 2'b10;
        else if (un == 0) st = 2'b11;
        else              st = 2'b00;
        v   = (st == 2'b10) ? fv : '0;
        a   = (st == 2'b10) ? fp : 1'b0;
        ovf = (nb > M);
    endtask

    task automatic drive_beat(input int b, input logic last);
        chk("in_ready_accum", in_ready, 1);
        chk("out_valid_accum", out_valid, 0);
        in_valid = 1'b1; in_last = last;
        in_mask = bm[b]; in_unassign = bu[b]; in_assignment = ba[b]; in_pole = bp[b]; in_vars = bv[b];
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_clause(input int hold);
        logic [1:0]   st;
        logic [W-1:0] v;
        logic         a, ovf;
        for (int b = 0; b < nb; b++) drive_beat(b, b == nb - 1);
        model(st, v, a, ovf);
        chk("out_valid_verdict", out_valid, 1);
        chk("in_ready_result", in_ready, 0);
        chk("status", out_status, st);
        chk("implied_var", out_implied_var, v);
        chk("new_assignment", out_new_assignment, a);
        chk("overflow", out_overflow, ovf);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_status", out_status, st);
            chk("hold_var", out_implied_var, v);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_status", out_status, 0);
        chk("rst_var", out_implied_var, 0);
        chk("rst_asg", out_new_assignment, 0);
        chk("rst_ovf", out_overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-beat conflict
        nb = 1; set_beat(0, 5'b11111, 5'b00000, 5'b00000, 5'b11111);
        send_clause(0);

        // UNIT from beat 2 slot 3, var 77, pole 0
        nb = 2;
        set_beat(0, 5'b11111, 5'b00000, 5'b00000, 5'b11111);
        set_beat(1, 5'b11111, 5'b01000, 5'b00000, 5'b10111);
        bv[1][3*W +: W] = 9'd77;
        send_clause(0);
        // same clause with verdict stalled 5 cycles
        send_clause(5);

        // one unassigned per beat -> UNRESOLVED
        set_beat(0, 5'b11111, 5'b00100, 5'b00000, 5'b11111);
        set_beat(1, 5'b11111, 5'b00001, 5'b00000, 5'b11111);
        send_clause(1);

        // SAT in beat 1, all unassigned in beat 2
        set_beat(0, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
        set_beat(1, 5'b11111, 5'b11111, 5'b00000, 5'b00000);
        send_clause(0);

        // no live literal at all -> CONFLICT
        nb = 3;
        for (int b = 0; b < nb; b++) set_beat(b, 5'b00000, 5'b11111, 5'b10101, 5'b10101);
        send_clause(0);

        // exactly MAX_CHUNKS beats: no overflow; MAX_CHUNKS+1: overflow
        nb = M;
        for (int b = 0; b < nb; b++) set_beat(b, 5'b11111, 5'b00000, 5'b00000, 5'b11111);
        send_clause(0);
        nb = M + 1;
        for (int b = 0; b < nb; b++) set_beat(b, 5'b11111, 5'b00000, 5'b00000, 5'b11111);
        set_beat(4, 5'b11111, 5'b00010, 5'b00000, 5'b11111);
        send_clause(0);

        // abort after two beats; the beat presented with abort is dropped
        nb = 2;
        set_beat(0, 5'b11111, 5'b11000, 5'b00000, 5'b11111);
        set_beat(1, 5'b11111, 5'b00011, 5'b00000, 5'b11111);
        drive_beat(0, 1'b0);
        drive_beat(1, 1'b0);
        chk("abort_in_ready", in_ready, 1);
        abort = 1'b1; in_valid = 1'b1; in_last = 1'b1;
        in_mask = 5'b11111; in_unassign = 5'b00000; in_assignment = 5'b00000; in_pole = 5'b11111;
        @(posedge clk); @(negedge clk);
        abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        chk("abort_drop_out_valid", out_valid, 0);
        // 7 beats after 2 aborted ones: leftover count would flag overflow / spoil UNIT
        nb = 7;
        for (int b = 0; b < nb; b++) set_beat(b, 5'b11111, 5'b00000, 5'b00000, 5'b11111);
        set_beat(0, 5'b11111, 5'b00100, 5'b00000, 5'b11011);
        send_clause(0);
        nb = 1; set_beat(0, 5'b00001, 5'b00000, 5'b00001, 5'b00001);
        send_clause(0);

        // reset mid-clause, then a UNIT clause must not see stale state
        set_beat(0, 5'b11111, 5'b11111, 5'b00000, 5'b00000);
        drive_beat(0, 1'b0);
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        nb = 1; set_beat(0, 5'b10000, 5'b10000, 5'b00000, 5'b10000);
        send_clause(0);

        // reset while verdict is pending
        nb = 1; set_beat(0, 5'b00010, 5'b00010, 5'b00000, 5'b00010);
        drive_beat(0, 1'b1);
        chk("pre_rst_status", out_status, 2'b10);
        rst_n = 1'b0; #1;
        chk("rst_result_out_valid", out_valid, 0);
        chk("rst_result_status", out_status, 0);
        chk("rst_result_var", out_implied_var, 0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);

        // random clauses
        for (int c = 0; c < 60; c++) begin
            int mode;
            nb   = $urandom_range(1, 10);
            mode = $urandom_range(0, 3);
            for (int b = 0; b < nb; b++) begin
                bm[b] = 5'($urandom);
                ba[b] = 5'($urandom);
                bp[b] = (mode == 0) ? 5'($urandom) : ~ba[b];
                bv[b] = 45'({$urandom, $urandom});
                if (mode == 2) bu[b] = (b == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'b00000;
                else           bu[b] = 5'($urandom & $urandom & $urandom);
            end
            send_clause($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
